psum_bank_scheduler: RTL and testbench
======================================

Name: psum_bank_scheduler

Overview:
- Sequences one psum SRAM bank of 512 x 21-bit entries.
- Shares the bank between three requesters:
  - PE psum writeback (WR),
  - accumulate readback to the PE cluster (RD),
  - read-out to the rearrange/im2col stage (RO).
- Generates the bank's write/read enables, addresses and `PSUM_DEPTH`. Runs one pass of `depth+1` entries per grant, starting at a per-pass base address.

Parameters:
- `BANK_DEPTH`, 512, bank entries; addresses wrap modulo this value.
- `ADDR_W`, 10, bank address port width; the MSB is always driven 0.

Ports:
- `clock` in 1: clock.
- `reset` in 1: synchronous, active-high.
- `cfg_psum_depth` in 5: entries per pass minus 1; sampled at grant.
- `wr_req` in 1: writeback pass request, level-sensitive.
- `wr_base` in 10: writeback start address; sampled at grant.
- `rd_req` in 1: accumulate-readback pass request, level-sensitive.
- `rd_base` in 10: readback start address; sampled at grant.
- `ro_req` in 1: read-out pass request, level-sensitive.
- `ro_base` in 10: read-out start address; sampled at grant.
- `wr_grant` out 1: one-cycle pulse when the WR pass starts.
- `rd_grant` out 1: one-cycle pulse when the RD pass starts.
- `ro_grant` out 1: one-cycle pulse when the RO pass starts.
- `pass_done` out 1: one-cycle pulse when any pass completes.
- `busy` out 1: high in any state except IDLE.
- `psum_data_in_valid` in 1: monitored copy of the bank write-data valid.
- `psum_data_out_ready` in 1: monitored copy of the bank read-data ready.
- `psum_write_en` out 1: to bank.
- `psum_write_addr` out 10: to bank.
- `psum_write_done` in 1: from bank.
- `psum_read_en` out 1: to bank.
- `psum_read_out_en` out 1: to bank.
- `psum_read_addr` out 10: to bank.
- `PSUM_DEPTH` out 5: to bank; holds the latched depth.

Behaviour:
- **Reset values:**
  - State IDLE.
  - All enables, grants, `pass_done` and `busy` are 0.
  - Addresses 0, `PSUM_DEPTH` 0, internal count 0.
- **States:** IDLE, WRITE, WDRAIN, READ, READOUT.
- **Arbitration in IDLE:** fixed priority WR > RD > RO.
  - On the grant cycle, latch base and depth, clear the count to 0, and pulse the matching grant.
  - The next state is WRITE, READ or READOUT.
  - Requests that arrive while busy are ignored until IDLE. A requester must hold its request until it sees its grant.
- **Address generation:** `addr = (base + count) mod 512`, 9-bit wrap, with `addr[9] = 0`. Example: base 510, count 3 → addr 1.
- **WRITE state:**
  - `psum_write_en` = 1 and `psum_write_addr` = addr.
  - A handshake is `psum_write_en & psum_data_in_valid`; on each handshake, count increments.
  - On the handshake where count == depth: go to WDRAIN. `psum_write_en` is 0 from the next cycle, so no extra write is accepted.
- **WDRAIN state:**
  - Wait for `psum_write_done`. The bank asserts it the cycle after the final handshake.
  - On `psum_write_done`: pulse `pass_done` and go to IDLE.
  - Watchdog: if `psum_write_done` has not arrived after 2 cycles in WDRAIN, still pulse `pass_done` and go to IDLE.
- **READ / READOUT states:**
  - `psum_read_en` (READ) or `psum_read_out_en` (READOUT) = 1, and `psum_read_addr` = addr.
  - A beat is `enable & psum_data_out_ready`; on each beat, count increments. The bank returns data 1 cycle after each beat.
  - On the beat where count == depth: deassert the enable next cycle, pulse `pass_done` in that next cycle, and go to IDLE.
  - While `psum_data_out_ready` = 0, address and count hold.
- **Exclusivity:** at most one of the three bank enables is high in any cycle; write and read never overlap.
- **`PSUM_DEPTH`:** driven from the latched depth throughout the pass and held after it.
- **Depth 0:** a single-entry pass, fully legal.
- **Reset mid-pass:** return to IDLE the next cycle with the enables deasserted. The bank's own counter is reset by the same reset.
- **`busy`:** high from the cycle after the grant through the `pass_done` cycle.

Test Plan:
- Reset, then `wr_req` with `wr_base` = 0, depth 3, valid held high → `wr_grant` pulse; writes at addresses 0, 1, 2, 3 on 4 consecutive cycles; `psum_write_en` low after the 4th; `pass_done` when `psum_write_done` arrives; no 5th write.
- `rd_req` with `rd_base` = 100, depth 2, `psum_data_out_ready` toggling 1,0,1,1 → `psum_read_addr` sequence 100, 101 (held), 101, 102; exactly 3 beats; `pass_done` one cycle after the last beat.
- `wr_req`, `rd_req` and `ro_req` all raised in the same IDLE cycle → WR granted first, then RD, then RO; `busy` covers each pass; never two enables high at once.
- `ro_req` with `ro_base` = 510, depth 4 → `psum_read_out_en` addresses 510, 511, 0, 1, 2.
- Depth 0 write with `wr_base` = 7 → one write at address 7, then `pass_done`; repeat with `psum_write_done` withheld → watchdog `pass_done` after 2 cycles.
- Reset asserted mid-READ at count 2 → next cycle IDLE, all enables 0, `busy` 0; a new `rd_req` restarts at count 0.

Source files
------------

// File: rtl/psum_bank_scheduler.sv
// Sequences one psum SRAM bank between PE writeback (WR), accumulate readback (RD)
// and read-out (RO); each grant runs one pass of depth+1 entries from a latched base.
module psum_bank_scheduler #(
  parameter int BANK_DEPTH = 512,
  parameter int ADDR_W     = 10
) (
  input  logic              clock,
  input  logic              reset,
  input  logic [4:0]        cfg_psum_depth,
  input  logic              wr_req,
  input  logic [ADDR_W-1:0] wr_base,
  input  logic              rd_req,
  input  logic [ADDR_W-1:0] rd_base,
  input  logic              ro_req,
  input  logic [ADDR_W-1:0] ro_base,
  output logic              wr_grant,
  output logic              rd_grant,
  output logic              ro_grant,
  output logic              pass_done,
  output logic              busy,
  input  logic              psum_data_in_valid,
  input  logic              psum_data_out_ready,
  output logic              psum_write_en,
  output logic [ADDR_W-1:0] psum_write_addr,
  input  logic              psum_write_done,
  output logic              psum_read_en,
  output logic              psum_read_out_en,
  output logic [ADDR_W-1:0] psum_read_addr,
  output logic [4:0]        PSUM_DEPTH
);

  localparam int IDX_W = $clog2(BANK_DEPTH);

  typedef enum logic [2:0] {
    S_IDLE,
    S_WRITE,
    S_WDRAIN,
    S_READ,
    S_READOUT
  } state_t;

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] base_q;
  logic [4:0]        depth_q;
  logic [4:0]        count_q;
  logic [1:0]        wd_cnt_q;
  logic              fin_q;

  logic              arb_ok;
  logic              any_grant;
  logic [ADDR_W-1:0] grant_base;
  logic              wr_hs;
  logic              rd_beat;
  logic              last;
  logic [IDX_W-1:0]  addr_idx;
  logic [ADDR_W-1:0] addr;

  // Bank addresses wrap inside the bank; the upper address bit stays 0.
  assign addr_idx = IDX_W'(base_q + ADDR_W'(count_q));
  assign addr     = {{(ADDR_W-IDX_W){1'b0}}, addr_idx};
  assign last     = (count_q == depth_q);
  assign wr_hs    = psum_write_en & psum_data_in_valid;
  assign rd_beat  = (psum_read_en | psum_read_out_en) & psum_data_out_ready;
  assign any_grant = wr_grant | rd_grant | ro_grant;

  // ---------------------------------------------------------------- state register
  always_ff @(posedge clock) begin
    // NOTE: registered state uses non-blocking assignment so every flop samples
    // pre-edge values regardless of process ordering.
    if (reset) state_q <= S_IDLE;
    else       state_q <= state_d;
  end

  // ---------------------------------------------------------------- next state
  always_comb begin
    // NOTE: default assignment first, so no path leaves state_d unassigned
    // and no latch is inferred.
    state_d = state_q;
    unique case (state_q)
      S_IDLE: begin
        if (wr_grant)      state_d = S_WRITE;
        else if (rd_grant) state_d = S_READ;
        else if (ro_grant) state_d = S_READOUT;
      end
      S_WRITE:   if (wr_hs && last) state_d = S_WDRAIN;
      S_WDRAIN:  if (pass_done)     state_d = S_IDLE;
      S_READ,
      S_READOUT: if (fin_q)         state_d = S_IDLE;
      default:   state_d = S_IDLE;
    endcase
  end

  // ---------------------------------------------------------------- outputs
  always_comb begin
    arb_ok           = (state_q == S_IDLE) && !reset;
    wr_grant         = arb_ok && wr_req;
    rd_grant         = arb_ok && !wr_req && rd_req;
    ro_grant         = arb_ok && !wr_req && !rd_req && ro_req;
    busy             = (state_q != S_IDLE);
    psum_write_en    = (state_q == S_WRITE);
    // fin_q marks the trailing cycle of a read pass: enable off, completion reported.
    psum_read_en     = (state_q == S_READ)    && !fin_q;
    psum_read_out_en = (state_q == S_READOUT) && !fin_q;
    pass_done        = ((state_q == S_WDRAIN) && (psum_write_done || wd_cnt_q == 2'd2)) ||
                       (((state_q == S_READ) || (state_q == S_READOUT)) && fin_q);
    psum_write_addr  = addr;
    psum_read_addr   = addr;
    PSUM_DEPTH       = depth_q;
  end

  always_comb begin
    grant_base = ro_base;
    if (wr_grant)      grant_base = wr_base;
    else if (rd_grant) grant_base = rd_base;
  end

  // ---------------------------------------------------------------- pass datapath
  always_ff @(posedge clock) begin
    if (reset) begin
      base_q   <= '0;
      depth_q  <= '0;
      count_q  <= '0;
      wd_cnt_q <= '0;
      fin_q    <= 1'b0;
    end else begin
      fin_q    <= rd_beat && last;
      // Bounds the wait for the bank's write-done after the final write.
      wd_cnt_q <= (state_q == S_WDRAIN) ? wd_cnt_q + 2'd1 : 2'd0;
      if (any_grant) begin
        base_q  <= grant_base;
        depth_q <= cfg_psum_depth;
        count_q <= '0;
      end else if (wr_hs || rd_beat) begin
        count_q <= count_q + 5'd1;
      end
    end
  end

endmodule

// File: tb/tb_psum_bank_scheduler.sv
// Directed bench for psum_bank_scheduler: inputs change on the falling edge and
// outputs are checked 1 ns later, well away from the rising edge.
module tb_psum_bank_scheduler;

  logic       clock = 1'b0;
  logic       reset;
  logic [4:0] cfg_psum_depth;
  logic       wr_req, rd_req, ro_req;
  logic [9:0] wr_base, rd_base, ro_base;
  logic       wr_grant, rd_grant, ro_grant, pass_done, busy;
  logic       psum_data_in_valid, psum_data_out_ready;
  logic       psum_write_en, psum_write_done, psum_read_en, psum_read_out_en;
  logic [9:0] psum_write_addr, psum_read_addr;
  logic [4:0] PSUM_DEPTH;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clock = ~clock;

  psum_bank_scheduler dut (
    .clock(clock), .reset(reset), .cfg_psum_depth(cfg_psum_depth),
    .wr_req(wr_req), .wr_base(wr_base), .rd_req(rd_req), .rd_base(rd_base),
    .ro_req(ro_req), .ro_base(ro_base),
    .wr_grant(wr_grant), .rd_grant(rd_grant), .ro_grant(ro_grant),
    .pass_done(pass_done), .busy(busy),
    .psum_data_in_valid(psum_data_in_valid), .psum_data_out_ready(psum_data_out_ready),
    .psum_write_en(psum_write_en), .psum_write_addr(psum_write_addr),
    .psum_write_done(psum_write_done), .psum_read_en(psum_read_en),
    .psum_read_out_en(psum_read_out_en), .psum_read_addr(psum_read_addr),
    .PSUM_DEPTH(PSUM_DEPTH)
  );

  // Bank enables must be mutually exclusive on every cycle.
  always @(negedge clock) begin
    n_cmp++;
    if ($countones({psum_write_en, psum_read_en, psum_read_out_en}) > 1) begin
      n_bad++;
      $display("FAIL exclusive_en: got wr=%b rd=%b ro=%b want at most one high",
               psum_write_en, psum_read_en, psum_read_out_en);
    end
  end

  task automatic tick();
    @(negedge clock);
  endtask

  task automatic test_reset();
    reset = 1'b1; cfg_psum_depth = 5'd0;
    wr_req = 1'b0; rd_req = 1'b0; ro_req = 1'b0;
    wr_base = '0; rd_base = '0; ro_base = '0;
    psum_data_in_valid = 1'b0; psum_data_out_ready = 1'b0; psum_write_done = 1'b0;
    repeat (3) tick();
    reset = 1'b0; #1;
    n_cmp++; if ({wr_grant, rd_grant, ro_grant, pass_done, busy} !== 5'b0) begin n_bad++;
      $display("FAIL reset_ctl: got %b want 00000", {wr_grant, rd_grant, ro_grant, pass_done, busy}); end
    n_cmp++; if ({psum_write_en, psum_read_en, psum_read_out_en} !== 3'b0) begin n_bad++;
      $display("FAIL reset_en: got %b want 000", {psum_write_en, psum_read_en, psum_read_out_en}); end
    n_cmp++; if (psum_write_addr !== 10'd0 || psum_read_addr !== 10'd0 || PSUM_DEPTH !== 5'd0) begin n_bad++;
      $display("FAIL reset_addr: got w=%0d r=%0d d=%0d want 0 0 0", psum_write_addr, psum_read_addr, PSUM_DEPTH); end
  endtask

  task automatic test_write();
    tick(); wr_req = 1'b1; wr_base = 10'd0; cfg_psum_depth = 5'd3; psum_data_in_valid = 1'b1; #1;
    n_cmp++; if (wr_grant !== 1'b1 || busy !== 1'b0) begin n_bad++;
      $display("FAIL wr_grant: got g=%b busy=%b want 1 0", wr_grant, busy); end
    for (int i = 0; i < 4; i++) begin
      tick(); wr_req = 1'b0; #1;
      n_cmp++; if (psum_write_en !== 1'b1 || psum_write_addr !== 10'(i) || busy !== 1'b1) begin n_bad++;
        $display("FAIL wr_beat%0d: got en=%b addr=%0d busy=%b want 1 %0d 1", i, psum_write_en, psum_write_addr, busy, i); end
    end
    n_cmp++; if (PSUM_DEPTH !== 5'd3) begin n_bad++;
      $display("FAIL wr_depth: got %0d want 3", PSUM_DEPTH); end
    tick(); psum_write_done = 1'b1; #1;
    n_cmp++; if (psum_write_en !== 1'b0 || pass_done !== 1'b1 || busy !== 1'b1) begin n_bad++;
      $display("FAIL wr_drain: got en=%b done=%b busy=%b want 0 1 1", psum_write_en, pass_done, busy); end
    tick(); psum_write_done = 1'b0; psum_data_in_valid = 1'b0; #1;
    n_cmp++; if (psum_write_en !== 1'b0 || pass_done !== 1'b0 || busy !== 1'b0) begin n_bad++;
      $display("FAIL wr_idle: got en=%b done=%b busy=%b want 0 0 0", psum_write_en, pass_done, busy); end
  endtask

  task automatic test_read_stall();
    logic [3:0] rdy;
    int exp_addr[4];
    int beats;
    rdy = 4'b1101;                    // bit i is ready in READ cycle i: 1,0,1,1
    exp_addr = '{100, 101, 101, 102};
    beats = 0;
    tick(); rd_req = 1'b1; rd_base = 10'd100; cfg_psum_depth = 5'd2; #1;
    n_cmp++; if (rd_grant !== 1'b1 || wr_grant !== 1'b0) begin n_bad++;
      $display("FAIL rd_grant: got rd=%b wr=%b want 1 0", rd_grant, wr_grant); end
    for (int i = 0; i < 4; i++) begin
      tick(); rd_req = 1'b0; psum_data_out_ready = rdy[i]; #1;
      n_cmp++; if (psum_read_en !== 1'b1 || psum_read_addr !== 10'(exp_addr[i])) begin n_bad++;
        $display("FAIL rd_cyc%0d: got en=%b addr=%0d want 1 %0d", i, psum_read_en, psum_read_addr, exp_addr[i]); end
      if (psum_read_en && psum_data_out_ready) beats++;
    end
    n_cmp++; if (beats !== 3) begin n_bad++;
      $display("FAIL rd_beats: got %0d want 3", beats); end
    tick(); #1;
    n_cmp++; if (psum_read_en !== 1'b0 || pass_done !== 1'b1 || busy !== 1'b1) begin n_bad++;
      $display("FAIL rd_done: got en=%b done=%b busy=%b want 0 1 1", psum_read_en, pass_done, busy); end
    tick(); psum_data_out_ready = 1'b0; #1;
    n_cmp++; if (busy !== 1'b0 || pass_done !== 1'b0) begin n_bad++;
      $display("FAIL rd_idle: got busy=%b done=%b want 0 0", busy, pass_done); end
  endtask

  task automatic test_priority();
    tick(); wr_req = 1'b1; rd_req = 1'b1; ro_req = 1'b1;
    wr_base = 10'd20; rd_base = 10'd40; ro_base = 10'd60; cfg_psum_depth = 5'd0;
    psum_data_in_valid = 1'b1; psum_data_out_ready = 1'b1; #1;
    n_cmp++; if ({wr_grant, rd_grant, ro_grant} !== 3'b100) begin n_bad++;
      $display("FAIL prio_wr: got %b want 100", {wr_grant, rd_grant, ro_grant}); end
    tick(); wr_req = 1'b0; #1;
    n_cmp++; if (psum_write_en !== 1'b1 || psum_write_addr !== 10'd20 || busy !== 1'b1) begin n_bad++;
      $display("FAIL prio_wr_pass: got en=%b addr=%0d busy=%b want 1 20 1", psum_write_en, psum_write_addr, busy); end
    tick(); psum_write_done = 1'b1; #1;
    n_cmp++; if (pass_done !== 1'b1 || rd_grant !== 1'b0) begin n_bad++;
      $display("FAIL prio_wr_done: got done=%b rdg=%b want 1 0", pass_done, rd_grant); end
    tick(); psum_write_done = 1'b0; #1;
    n_cmp++; if ({wr_grant, rd_grant, ro_grant} !== 3'b010 || busy !== 1'b0) begin n_bad++;
      $display("FAIL prio_rd: got %b busy=%b want 010 0", {wr_grant, rd_grant, ro_grant}, busy); end
    tick(); rd_req = 1'b0; #1;
    n_cmp++; if (psum_read_en !== 1'b1 || psum_read_addr !== 10'd40 || busy !== 1'b1) begin n_bad++;
      $display("FAIL prio_rd_pass: got en=%b addr=%0d busy=%b want 1 40 1", psum_read_en, psum_read_addr, busy); end
    tick(); #1;
    n_cmp++; if (pass_done !== 1'b1 || busy !== 1'b1) begin n_bad++;
      $display("FAIL prio_rd_done: got done=%b busy=%b want 1 1", pass_done, busy); end
    tick(); #1;
    n_cmp++; if ({wr_grant, rd_grant, ro_grant} !== 3'b001 || busy !== 1'b0) begin n_bad++;
      $display("FAIL prio_ro: got %b busy=%b want 001 0", {wr_grant, rd_grant, ro_grant}, busy); end
    tick(); ro_req = 1'b0; #1;
    n_cmp++; if (psum_read_out_en !== 1'b1 || psum_read_addr !== 10'd60) begin n_bad++;
      $display("FAIL prio_ro_pass: got en=%b addr=%0d want 1 60", psum_read_out_en, psum_read_addr); end
    tick(); #1;
    n_cmp++; if (pass_done !== 1'b1 || busy !== 1'b1) begin n_bad++;
      $display("FAIL prio_ro_done: got done=%b busy=%b want 1 1", pass_done, busy); end
    tick(); psum_data_in_valid = 1'b0; psum_data_out_ready = 1'b0; #1;
    n_cmp++; if (busy !== 1'b0 || {wr_grant, rd_grant, ro_grant} !== 3'b000) begin n_bad++;
      $display("FAIL prio_idle: got busy=%b g=%b want 0 000", busy, {wr_grant, rd_grant, ro_grant}); end
  endtask

  task automatic test_readout_wrap();
    int exp_addr[5];
    exp_addr = '{510, 511, 0, 1, 2};
    tick(); ro_req = 1'b1; ro_base = 10'd510; cfg_psum_depth = 5'd4; psum_data_out_ready = 1'b1; #1;
    n_cmp++; if (ro_grant !== 1'b1) begin n_bad++;
      $display("FAIL ro_grant: got %b want 1", ro_grant); end
    for (int i = 0; i < 5; i++) begin
      tick(); ro_req = 1'b0; #1;
      n_cmp++; if (psum_read_out_en !== 1'b1 || psum_read_en !== 1'b0 || psum_read_addr !== 10'(exp_addr[i])) begin n_bad++;
        $display("FAIL ro_wrap%0d: got en=%b addr=%0d want 1 %0d", i, psum_read_out_en, psum_read_addr, exp_addr[i]); end
    end
    tick(); #1;
    n_cmp++; if (psum_read_out_en !== 1'b0 || pass_done !== 1'b1) begin n_bad++;
      $display("FAIL ro_done: got en=%b done=%b want 0 1", psum_read_out_en, pass_done); end
    tick(); psum_data_out_ready = 1'b0; #1;
    n_cmp++; if (busy !== 1'b0) begin n_bad++;
      $display("FAIL ro_idle: got busy=%b want 0", busy); end
  endtask

  task automatic test_depth0_watchdog();
    for (int pass = 0; pass < 2; pass++) begin
      tick(); wr_req = 1'b1; wr_base = 10'd7; cfg_psum_depth = 5'd0; psum_data_in_valid = 1'b1; #1;
      n_cmp++; if (wr_grant !== 1'b1) begin n_bad++;
        $display("FAIL d0_grant%0d: got %b want 1", pass, wr_grant); end
      tick(); wr_req = 1'b0; #1;
      n_cmp++; if (psum_write_en !== 1'b1 || psum_write_addr !== 10'd7) begin n_bad++;
        $display("FAIL d0_write%0d: got en=%b addr=%0d want 1 7", pass, psum_write_en, psum_write_addr); end
      if (pass == 0) begin
        tick(); psum_write_done = 1'b1; #1;
        n_cmp++; if (psum_write_en !== 1'b0 || pass_done !== 1'b1) begin n_bad++;
          $display("FAIL d0_done: got en=%b done=%b want 0 1", psum_write_en, pass_done); end
        tick(); psum_write_done = 1'b0; #1;
      end else begin
        for (int w = 0; w < 2; w++) begin
          tick(); #1;
          n_cmp++; if (pass_done !== 1'b0 || busy !== 1'b1 || psum_write_en !== 1'b0) begin n_bad++;
            $display("FAIL wd_wait%0d: got done=%b busy=%b en=%b want 0 1 0", w, pass_done, busy, psum_write_en); end
        end
        tick(); #1;
        n_cmp++; if (pass_done !== 1'b1 || busy !== 1'b1) begin n_bad++;
          $display("FAIL wd_fire: got done=%b busy=%b want 1 1", pass_done, busy); end
        tick(); #1;
      end
      n_cmp++; if (psum_write_en !== 1'b0 || busy !== 1'b0 || pass_done !== 1'b0) begin n_bad++;
        $display("FAIL d0_idle%0d: got en=%b busy=%b done=%b want 0 0 0", pass, psum_write_en, busy, pass_done); end
    end
    psum_data_in_valid = 1'b0;
  endtask

  task automatic test_reset_mid_read();
    tick(); rd_req = 1'b1; rd_base = 10'd200; cfg_psum_depth = 5'd5; psum_data_out_ready = 1'b1; #1;
    n_cmp++; if (rd_grant !== 1'b1) begin n_bad++;
      $display("FAIL mr_grant: got %b want 1", rd_grant); end
    for (int i = 0; i < 3; i++) begin
      tick(); rd_req = 1'b0; #1;
      n_cmp++; if (psum_read_en !== 1'b1 || psum_read_addr !== 10'(200 + i)) begin n_bad++;
        $display("FAIL mr_beat%0d: got en=%b addr=%0d want 1 %0d", i, psum_read_en, psum_read_addr, 200 + i); end
    end
    reset = 1'b1;
    tick(); reset = 1'b0; #1;
    n_cmp++; if ({psum_write_en, psum_read_en, psum_read_out_en, busy, pass_done} !== 5'b0) begin n_bad++;
      $display("FAIL mr_reset: got %b want 00000", {psum_write_en, psum_read_en, psum_read_out_en, busy, pass_done}); end
    n_cmp++; if (psum_read_addr !== 10'd0 || PSUM_DEPTH !== 5'd0) begin n_bad++;
      $display("FAIL mr_reset_addr: got addr=%0d d=%0d want 0 0", psum_read_addr, PSUM_DEPTH); end
    tick(); rd_req = 1'b1; rd_base = 10'd300; cfg_psum_depth = 5'd1; #1;
    n_cmp++; if (rd_grant !== 1'b1) begin n_bad++;
      $display("FAIL mr_regrant: got %b want 1", rd_grant); end
    for (int i = 0; i < 2; i++) begin
      tick(); rd_req = 1'b0; #1;
      n_cmp++; if (psum_read_en !== 1'b1 || psum_read_addr !== 10'(300 + i)) begin n_bad++;
        $display("FAIL mr_restart%0d: got en=%b addr=%0d want 1 %0d", i, psum_read_en, psum_read_addr, 300 + i); end
    end
    tick(); #1;
    n_cmp++; if (pass_done !== 1'b1 || psum_read_en !== 1'b0) begin n_bad++;
      $display("FAIL mr_done: got done=%b en=%b want 1 0", pass_done, psum_read_en); end
    tick(); psum_data_out_ready = 1'b0; #1;
  endtask

  initial begin
    test_reset();
    test_write();
    test_read_stall();
    test_priority();
    test_readout_wrap();
    test_depth0_watchdog();
    test_reset_mid_read();
    repeat (2) tick();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #50000;
    $display("FAIL timeout: got no end of test by 50000 ns want completion");
    $fatal(1, "bench time limit");
  end

endmodule
